// File: rtl/ds_operand_stage_pkg.sv
// Shared definitions for the decode-stage operand front end: bus widths,
// forwarding source indices and instruction field positions.
package ds_operand_stage_pkg;

  localparam int FWD_ES = 0;
  localparam int FWD_MS = 1;

  // MIPS-style register fields inside the instruction word
  localparam int RS_LSB = 21;
  localparam int RT_LSB = 16;

  function automatic int fs_to_ds_bus_wd(input int data_w, input int pc_w);
    return data_w + pc_w;
  endfunction

  function automatic int fwd_dest_wd(input int num_fwd, input int reg_aw);
    return num_fwd * reg_aw;
  endfunction

  function automatic int fwd_data_wd(input int num_fwd, input int data_w);
    return num_fwd * data_w;
  endfunction

endpackage

// File: rtl/ds_operand_stage_fwd_sel.sv
// Single-operand priority selector: r0, youngest forward match, WB bypass,
// then register file. Also reports whether the winning forward is blocked.
module ds_fwd_sel
  import ds_operand_stage_pkg::*;
#(
  parameter int NUM_FWD = 2,
  parameter int DATA_W  = 32,
  parameter int REG_AW  = 5
) (
  input  logic [REG_AW-1:0]         addr,
  input  logic [NUM_FWD-1:0]        fwd_valid,
  input  logic [NUM_FWD-1:0]        fwd_blk,
  input  logic [NUM_FWD*REG_AW-1:0] fwd_dest,
  input  logic [NUM_FWD*DATA_W-1:0] fwd_data,
  input  logic                      rf_we,
  input  logic [REG_AW-1:0]         rf_waddr,
  input  logic [DATA_W-1:0]         rf_wdata,
  input  logic [DATA_W-1:0]         rf_rdata,
  output logic [DATA_W-1:0]         value,
  output logic                      blk
);

  always_comb begin
    value = rf_rdata;
    blk   = 1'b0;
    if (rf_we && rf_waddr == addr) value = rf_wdata;
    // Walk oldest to youngest so the lowest matching index is left standing
    for (int i = NUM_FWD - 1; i >= 0; i--) begin
      if (fwd_valid[i] && fwd_dest[i*REG_AW +: REG_AW] == addr) begin
        value = fwd_data[i*DATA_W +: DATA_W];
        blk   = fwd_blk[i];
      end
    end
    if (addr == '0) begin
      value = '0;
      blk   = 1'b0;
    end
  end

endmodule

// File: rtl/ds_operand_stage.sv
// Decode-stage operand front end: FS->DS register, handshake, regfile,
// forwarding and load-use interlock. Optional stall counter: DS_STALL_CNT_EN.
module ds_operand_stage
  import ds_operand_stage_pkg::*;
#(
  parameter int NUM_FWD = 2,
  parameter int DATA_W  = 32,
  parameter int REG_AW  = 5,
  parameter int PC_W    = 32
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      flush,
  input  logic                      es_allowin,
  output logic                      ds_allowin,
  input  logic                      fs_to_ds_valid,
  input  logic [DATA_W+PC_W-1:0]    fs_to_ds_bus,
  output logic                      ds_to_es_valid,
  output logic [DATA_W-1:0]         ds_inst,
  output logic [PC_W-1:0]           ds_pc,
  input  logic                      use_rs,
  input  logic                      use_rt,
  input  logic [NUM_FWD-1:0]        fwd_valid,
  input  logic [NUM_FWD-1:0]        fwd_blk,
  input  logic [NUM_FWD*REG_AW-1:0] fwd_dest,
  input  logic [NUM_FWD*DATA_W-1:0] fwd_data,
  input  logic                      rf_we,
  input  logic [REG_AW-1:0]         rf_waddr,
  input  logic [DATA_W-1:0]         rf_wdata,
  output logic [DATA_W-1:0]         rs_value,
  output logic [DATA_W-1:0]         rt_value,
  output logic                      ds_stall,
  output logic [31:0]               stall_cnt
);

  localparam int BUS_W = DATA_W + PC_W;

  // Handshake: a stage transfers when its valid and the consumer's allowin
  // are both high in the same cycle; allowin never depends on valid of the
  // producer, so no combinational loop exists across the boundary.
  logic              ds_valid;
  logic              ds_ready_go;
  logic [BUS_W-1:0]  bus_r;
  logic [DATA_W-1:0] rf_mem [2**REG_AW];
  logic [REG_AW-1:0] rs_addr;
  logic [REG_AW-1:0] rt_addr;
  logic              rs_blk;
  logic              rt_blk;

  assign ds_inst = bus_r[BUS_W-1:PC_W];
  assign ds_pc   = bus_r[PC_W-1:0];
  assign rs_addr = ds_inst[RS_LSB +: REG_AW];
  assign rt_addr = ds_inst[RT_LSB +: REG_AW];

  assign ds_ready_go    = !((use_rs && rs_blk) || (use_rt && rt_blk));
  assign ds_allowin     = !ds_valid || (ds_ready_go && es_allowin);
  assign ds_to_es_valid = ds_valid && ds_ready_go;
  assign ds_stall       = ds_valid && !ds_ready_go;

  always_ff @(posedge clk) begin
    if (reset) begin
      ds_valid <= 1'b0;
      bus_r    <= '0;
    end else if (flush) begin
      ds_valid <= 1'b0;
    end else if (ds_allowin) begin
      ds_valid <= fs_to_ds_valid;
      if (fs_to_ds_valid) bus_r <= fs_to_ds_bus;
    end
  end

  // Register file contents are architectural state, not reset
  always_ff @(posedge clk) begin
    if (rf_we && rf_waddr != '0) rf_mem[rf_waddr] <= rf_wdata;
  end

  ds_fwd_sel #(.NUM_FWD(NUM_FWD), .DATA_W(DATA_W), .REG_AW(REG_AW)) u_rs_sel (
    .addr(rs_addr), .fwd_valid(fwd_valid), .fwd_blk(fwd_blk),
    .fwd_dest(fwd_dest), .fwd_data(fwd_data), .rf_we(rf_we),
    .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .rf_rdata(rf_mem[rs_addr]),
    .value(rs_value), .blk(rs_blk)
  );

  ds_fwd_sel #(.NUM_FWD(NUM_FWD), .DATA_W(DATA_W), .REG_AW(REG_AW)) u_rt_sel (
    .addr(rt_addr), .fwd_valid(fwd_valid), .fwd_blk(fwd_blk),
    .fwd_dest(fwd_dest), .fwd_data(fwd_data), .rf_we(rf_we),
    .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .rf_rdata(rf_mem[rt_addr]),
    .value(rt_value), .blk(rt_blk)
  );

`ifdef DS_STALL_CNT_EN
  logic [31:0] stall_cnt_r;

  always_ff @(posedge clk) begin
    if (reset) stall_cnt_r <= '0;
    else if (ds_stall && stall_cnt_r != 32'hFFFF_FFFF) stall_cnt_r <= stall_cnt_r + 32'd1;
  end

  assign stall_cnt = stall_cnt_r;
`else
  assign stall_cnt = 32'd0;
`endif

endmodule

// File: doc/ds_operand_stage.md
Name: ds_operand_stage

Overview:
- Parametrised decode-stage operand front end: owns the FS→DS pipeline register, the valid/allowin handshake, the register file read, N-source forwarding and load-use interlock.
- Improvements over the current decode stage:
  - Forwarding source count is a parameter.
  - Interlock considers only operands the instruction actually reads.
  - r0 is never forwarded or blocked.
  - Supports a flush.
- Sits between IF and the decoder/EX; the decoder consumes ds_inst and returns operand-use flags.

Parameters:
- NUM_FWD, 2, number of forwarding sources; index 0 is youngest (EX), highest priority.
- DATA_W, 32, register data width.
- REG_AW, 5, register address width; 2**REG_AW registers.
- PC_W, 32, PC width.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- flush  in  1  discard DS content (exception/redirect)
- es_allowin  in  1  EX can accept
- ds_allowin  out  1  DS can accept
- fs_to_ds_valid  in  1  IF output valid
- fs_to_ds_bus  in  DATA_W+PC_W  {inst, pc}
- ds_to_es_valid  out  1  DS output valid
- ds_inst  out  DATA_W  latched instruction
- ds_pc  out  PC_W  latched PC
- use_rs  in  1  decoder: instruction reads rs
- use_rt  in  1  decoder: instruction reads rt
- fwd_valid  in  NUM_FWD  source i will write fwd_dest[i]
- fwd_blk  in  NUM_FWD  source i data not yet available (load in flight)
- fwd_dest  in  NUM_FWD*REG_AW  flattened destinations
- fwd_data  in  NUM_FWD*DATA_W  flattened data
- rf_we  in  1  WB write enable
- rf_waddr  in  REG_AW  WB address
- rf_wdata  in  DATA_W  WB data
- rs_value  out  DATA_W  resolved rs operand
- rt_value  out  DATA_W  resolved rt operand
- ds_stall  out  1  ds_valid && !ds_ready_go
- stall_cnt  out  32  stall cycle count (see optional feature)

Behaviour:
- Reset: ds_valid=0, bus register=0, stall_cnt=0. Consequences: ds_to_es_valid=0, ds_allowin=1, ds_stall=0.
- Handshake:
  - ds_allowin = !ds_valid || (ds_ready_go && es_allowin).
  - ds_to_es_valid = ds_valid && ds_ready_go.
- Pipeline register update, at posedge:
  - flush: ds_valid<=0; bus register holds. flush overrides a simultaneous load.
  - else if ds_allowin: ds_valid<=fs_to_ds_valid; bus register loads only when fs_to_ds_valid.
  - Latency: IF→DS output 1 cycle. Operands are combinational from the register.
- Operand resolution, per operand s∈{rs,rt}, priority highest first:
  - addr==0 → 0.
  - lowest i with fwd_valid[i] && fwd_dest[i]==addr → fwd_data[i].
  - rf_we && rf_waddr==addr → rf_wdata (WB bypass).
  - regfile read.
- Block condition:
  - hit_blk(s) = use_s && addr≠0 && the winning forward match i has fwd_blk[i].
  - An older non-blocked match does not clear a younger blocked one.
  - ds_ready_go = !(hit_blk(rs) || hit_blk(rt)).
  - fwd_blk[i] without fwd_valid[i] is ignored.
- Stall: ds_stall=1 while blocked. ds_inst/ds_pc hold. Operands update each cycle as sources advance.
- Flush during a stall: next cycle ds_valid=0 and ds_allowin=1.
- Same register in rs and rt: both resolve identically.
- Write to r0 by WB or any source: never visible; r0 reads 0.

Optional Feature:
- DS_STALL_CNT_EN defined:
  - stall_cnt increments each cycle ds_stall=1.
  - Saturates at 32'hFFFF_FFFF.
  - Clears on reset only; flush does not clear it.
- Undefined: stall_cnt tied to 0; no counter logic.

Decomposition:
- Shared header mycpu.h holds:
  - FS_TO_DS_BUS_WD.
  - Flattened forward-bus widths derived from NUM_FWD.
  - Source index constants FWD_ES=0, FWD_MS=1.
- Existing regfile instantiated unchanged.
- One natural sub-module, ds_fwd_sel:
  - Single-operand priority selector, parametrised by NUM_FWD.
  - Outputs value and blocked flag; instantiated twice (rs, rt).

Test Plan:
- Reset high 2 cycles, then deassert, no input → ds_to_es_valid=0, ds_allowin=1, stall_cnt=0.
- Back-to-back: inst addu $3,$1,$2 @pc 0xBFC00000 then next; es_allowin=1 → each appears on ds_inst one cycle after acceptance; ds_to_es_valid=1 every cycle.
- Priority:
  - Stimulus: fwd0 dest=3 data=0x11, fwd1 dest=3 data=0x22, WB addr 3 data=0x33, use_rs=1, rs=3.
  - Response: rs_value=0x11. Drop fwd0 → 0x22. Drop fwd1 → 0x33.
- Load-use:
  - Stimulus: fwd_blk[0]=1 dest=5, rt=5, use_rt=1 for 2 cycles.
  - Response: ds_stall=1, ds_to_es_valid=0, ds_allowin=0, ds_pc held. Clear blk → issues next cycle.
  - Same case with use_rt=0 → no stall.
- r0: fwd0 dest=0 blk=1 data=0xDEAD, rs=0, use_rs=1 → rs_value=0, no stall.
- Flush mid-stall with fs_to_ds_valid=1 → next cycle ds_valid=0.
- With DS_STALL_CNT_EN, 3-cycle stall → stall_cnt=3.
